// File: rtl/key_debounce.sv
// Debounces a raw, asynchronous, bouncing level into a clean synchronous level.
// Also keeps a saturating count of transitions that bounced back before qualifying.
module key_debounce #(
  parameter int STABLE   = 1_000_000,
  parameter int CNT_W    = 20,
  parameter int GLITCH_W = 8
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                dat_i,
  input  logic                glitch_clr,
  output logic                dat_o,
  output logic                busy,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  typedef enum logic [1:0] {
    LOW   = 2'd0,
    CHK_H = 2'd1,
    HIGH  = 2'd2,
    CHK_L = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(STABLE - 1);
  localparam logic [GLITCH_W-1:0] GLITCH_MAX = '1;

  function automatic logic [GLITCH_W-1:0] sat_inc(input logic [GLITCH_W-1:0] v);
    return (v == GLITCH_MAX) ? v : v + GLITCH_W'(1);
  endfunction

  logic                sync_p0;
  logic                sync_p1;
  state_t              state;
  state_t              state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_nxt;
  logic                abort;
  logic [GLITCH_W-1:0] glitch_nxt;

  // Stage p0/p1: two-flop synchroniser; only sync_p1 is seen by the FSM.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= dat_i;
      sync_p1 <= sync_p0;
    end
  end

  // Qualification FSM: any disagreement with the settled level during a check aborts it.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    abort     = 1'b0;
    case (state)
      LOW: begin
        if (sync_p1) begin
          state_nxt = CHK_H;
          cnt_nxt   = '0;
        end
      end
      CHK_H: begin
        if (!sync_p1) begin
          state_nxt = LOW;
          cnt_nxt   = '0;
          abort     = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_nxt = HIGH;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      HIGH: begin
        if (!sync_p1) begin
          state_nxt = CHK_L;
          cnt_nxt   = '0;
        end
      end
      CHK_L: begin
        if (sync_p1) begin
          state_nxt = HIGH;
          cnt_nxt   = '0;
          abort     = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_nxt = LOW;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = LOW;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Clear takes priority over a coincident abort.
  always_comb begin
    glitch_nxt = glitch_cnt;
    if (glitch_clr) begin
      glitch_nxt = '0;
    end else if (abort) begin
      glitch_nxt = sat_inc(glitch_cnt);
    end
  end

  // Stage p2: state, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= LOW;
      cnt        <= '0;
      dat_o      <= 1'b0;
      busy       <= 1'b0;
      glitch_cnt <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      dat_o      <= (state_nxt == HIGH) || (state_nxt == CHK_L);
      busy       <= (state_nxt == CHK_H) || (state_nxt == CHK_L);
      glitch_cnt <= glitch_nxt;
    end
  end

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: run-length model checked every cycle plus directed literal checks.
module tb_key_debounce;

  logic       clk = 1'b0;
  logic       rstn_a = 1'b0;
  logic       dat_i_a = 1'b1;
  logic       clr_a = 1'b0;
  logic       dat_o_a;
  logic       busy_a;
  logic [2:0] glitch_a;

  logic       rstn_b = 1'b0;
  logic       dat_i_b = 1'b0;
  logic       clr_b = 1'b0;
  logic       dat_o_b;
  logic       busy_b;
  logic [2:0] glitch_b;

  int compared = 0;
  int mismatched = 0;
  bit checking = 1'b0;

  always #5 clk = ~clk;

  key_debounce #(.STABLE(4), .CNT_W(4), .GLITCH_W(3)) dut_a (
    .clk(clk), .rstn(rstn_a), .dat_i(dat_i_a), .glitch_clr(clr_a),
    .dat_o(dat_o_a), .busy(busy_a), .glitch_cnt(glitch_a)
  );

  key_debounce #(.STABLE(1), .CNT_W(2), .GLITCH_W(3)) dut_b (
    .clk(clk), .rstn(rstn_b), .dat_i(dat_i_b), .glitch_clr(clr_b),
    .dat_o(dat_o_b), .busy(busy_b), .glitch_cnt(glitch_b)
  );

  // Model: run = consecutive edges at which the synchronised input disagreed with the output.
  typedef struct {
    int s1;
    int s;
    int out;
    int run;
    int glitch;
  } mdl_t;

  mdl_t ma = '{0, 0, 0, 0, 0};
  mdl_t mb = '{0, 0, 0, 0, 0};

  function automatic mdl_t mstep(mdl_t m, logic rstn, logic din, logic clr, int stable, int gmax);
    mdl_t n;
    bit aborted;
    n = m;
    aborted = 1'b0;
    if (!rstn) begin
      n = '{0, 0, 0, 0, 0};
      return n;
    end
    n.s1 = int'(din);
    n.s  = m.s1;
    if (m.s != m.out) begin
      n.run = m.run + 1;
      if (n.run == stable + 1) begin
        n.out = 1 - m.out;
        n.run = 0;
      end
    end else begin
      aborted = (m.run > 0);
      n.run = 0;
    end
    if (clr) n.glitch = 0;
    else if (aborted && m.glitch < gmax) n.glitch = m.glitch + 1;
    return n;
  endfunction

  always @(posedge clk) begin
    ma = mstep(ma, rstn_a, dat_i_a, clr_a, 4, 7);
    mb = mstep(mb, rstn_b, dat_i_b, clr_b, 1, 7);
  end

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      chk("model_a_dat_o", int'(dat_o_a), ma.out);
      chk("model_a_busy", int'(busy_a), int'(ma.run > 0));
      chk("model_a_glitch", int'(glitch_a), ma.glitch);
      chk("model_b_dat_o", int'(dat_o_b), mb.out);
      chk("model_b_busy", int'(busy_b), int'(mb.run > 0));
      chk("model_b_glitch", int'(glitch_b), mb.glitch);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive a level change on instance A and check 6-edge latency and 4 busy cycles.
  task automatic trans_a(input logic val, input string name);
    int nb;
    nb = 0;
    dat_i_a = val;
    for (int i = 1; i <= 10; i++) begin
      step(1);
      if (busy_a) nb++;
      if (i == 6) chk({name, "_dat_before"}, int'(dat_o_a), int'(!val));
      if (i == 7) chk({name, "_dat_after"}, int'(dat_o_a), int'(val));
    end
    chk({name, "_busy_cycles"}, nb, 4);
  endtask

  initial begin
    // Scenario 1: reset with input high, then release.
    step(1);
    checking = 1'b1;
    step(2);
    chk("rst_dat_o", int'(dat_o_a), 0);
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_glitch", int'(glitch_a), 0);
    rstn_a = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step(1);
      if (i == 6) begin
        chk("s1_dat_k5", int'(dat_o_a), 0);
        chk("s1_busy_k5", int'(busy_a), 1);
      end
      if (i == 7) begin
        chk("s1_dat_k6", int'(dat_o_a), 1);
        chk("s1_busy_k6", int'(busy_a), 0);
      end
    end
    dat_i_a = 1'b0;
    step(12);
    chk("s1_settle_low", int'(dat_o_a), 0);

    // Scenario 2: clean rise, hold, clean fall.
    trans_a(1'b1, "s2_rise");
    trans_a(1'b0, "s2_fall");
    chk("s2_glitch", int'(glitch_a), 0);

    // Scenario 3: bounce 1,1,0 then held high.
    dat_i_a = 1'b1;
    step(2);
    dat_i_a = 1'b0;
    step(1);
    dat_i_a = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step(1);
      if (i == 6) chk("s3_dat_k5", int'(dat_o_a), 0);
      if (i == 7) chk("s3_dat_k6", int'(dat_o_a), 1);
    end
    chk("s3_glitch", int'(glitch_a), 1);
    dat_i_a = 1'b0;
    step(10);
    rstn_a = 1'b0;
    step(2);
    rstn_a = 1'b1;
    step(2);

    // Scenario 4: ten single-cycle pulses saturate the glitch counter.
    for (int p = 0; p < 10; p++) begin
      dat_i_a = 1'b1;
      step(1);
      dat_i_a = 1'b0;
      for (int i = 0; i < 7; i++) begin
        step(1);
        chk("s4_dat_low", int'(dat_o_a), 0);
      end
      chk("s4_glitch", int'(glitch_a), (p + 1 < 7) ? p + 1 : 7);
    end
    dat_i_a = 1'b1;
    step(1);
    dat_i_a = 1'b0;
    step(2);
    chk("s4_pre_clr_glitch", int'(glitch_a), 7);
    chk("s4_pre_clr_busy", int'(busy_a), 1);
    clr_a = 1'b1;
    step(1);
    clr_a = 1'b0;
    chk("s4_clr_vs_abort", int'(glitch_a), 0);
    chk("s4_abort_busy", int'(busy_a), 0);
    step(4);

    // Scenario 5: reset while qualifying with cnt=2.
    dat_i_a = 1'b1;
    step(5);
    chk("s5_busy_cnt2", int'(busy_a), 1);
    rstn_a = 1'b0;
    step(1);
    chk("s5_rst_dat", int'(dat_o_a), 0);
    chk("s5_rst_busy", int'(busy_a), 0);
    chk("s5_rst_glitch", int'(glitch_a), 0);
    rstn_a = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step(1);
      if (i == 6) chk("s5_dat_k5", int'(dat_o_a), 0);
      if (i == 7) chk("s5_dat_k6", int'(dat_o_a), 1);
    end
    chk("s5_glitch_after", int'(glitch_a), 0);

    // Scenario 6: STABLE=1 instance.
    rstn_b = 1'b1;
    step(3);
    dat_i_b = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step(1);
      if (i == 3) begin
        chk("s6_dat_k2", int'(dat_o_b), 0);
        chk("s6_busy_k2", int'(busy_b), 1);
      end
      if (i == 4) begin
        chk("s6_dat_k3", int'(dat_o_b), 1);
        chk("s6_busy_k3", int'(busy_b), 0);
      end
    end
    step(3);
    dat_i_b = 1'b0;
    step(1);
    dat_i_b = 1'b1;
    step(2);
    chk("s6_chk_l_busy", int'(busy_b), 1);
    chk("s6_chk_l_dat", int'(dat_o_b), 1);
    step(1);
    chk("s6_abort_busy", int'(busy_b), 0);
    chk("s6_abort_dat", int'(dat_o_b), 1);
    chk("s6_abort_glitch", int'(glitch_b), 1);
    step(5);
    chk("s6_hold_dat", int'(dat_o_b), 1);

    step(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/key_debounce.md
# key_debounce

Input-conditioning stage that sits directly upstream of the `edge_det` block. It takes a raw, asynchronous, bouncing level (push-button, mechanical switch, external strobe) and synchronises it into the `clk` domain. It then qualifies each transition with a stability counter and presents a clean level `dat_o`, which the edge detector's `dat_i` consumes. It also counts rejected (bounced) transitions for diagnostics.

## Interface
- `STABLE`, default 1_000_000: number of consecutive cycles the synchronised input must hold a new value before `dat_o` follows (20 ms at 50 MHz). Legal range is 1 .. 2^`CNT_W`-1.
- `CNT_W`, default 20: width of the stability counter.
- `GLITCH_W`, default 8: width of the rejected-transition counter.

Ports:
- `clk` input 1: single clock; all logic is on its rising edge.
- `rstn` input 1: reset, synchronous and active-low.
- `dat_i` input 1: raw asynchronous level, bouncing allowed.
- `glitch_clr` input 1: synchronous clear of `glitch_cnt`.
- `dat_o` output 1: debounced, synchronised level. Registered.
- `busy` output 1: high while a candidate transition is being qualified. Registered.
- `glitch_cnt` output `GLITCH_W`: saturating count of aborted transitions. Registered.

## Operation
**Reset**
- When `rstn`=0 at a clock edge, the following are cleared to 0: both synchroniser flops, the counter, `dat_o`, `busy` and `glitch_cnt`. The FSM goes to LOW.
- A reset mid-qualification discards the candidate and does not count as a glitch.

**Synchroniser**
- Two-flop chain: `dat_i` → `s1` → `s`.
- The FSM only ever looks at `s`.

**FSM**: four states, LOW, CHK_H, HIGH, CHK_L.
- LOW (`dat_o`=0): if `s`=1, go to CHK_H with cnt=0.
- CHK_H (`dat_o`=0, `busy`=1):
  - If `s`=0: go to LOW, cnt=0, `glitch_cnt`+1.
  - Else if cnt==`STABLE`-1: go to HIGH, `dat_o`=1.
  - Otherwise cnt+1.
- HIGH and CHK_L: mirror images of LOW and CHK_H with polarities swapped.
- `busy`=1 exactly in CHK_H and CHK_L.

**Counter and width rules**
- cnt is `CNT_W` bits and never exceeds `STABLE`-1.
- cnt is cleared on every state entry.
- `glitch_cnt` saturates at 2^`GLITCH_W`-1 and never wraps.

**`glitch_clr`**
- `glitch_clr`=1 forces `glitch_cnt` to 0.
- If a clear and an abort land in the same cycle, the clear wins: result is 0.

## Timing
**Rising latency**
- Let edge k be the first clock edge at which `s1` captures a new `dat_i` value that then holds.
- `s` changes at edge k+1.
- The FSM enters CHK at edge k+2, and `busy` rises there.
- `dat_o` changes and `busy` falls at edge k+2+`STABLE`.
- Example: `STABLE`=4 gives `dat_o` at edge k+6.

**Falling latency**: identical to the rising latency.

**Pulse rejection**: any excursion of `s` shorter than `STABLE`+1 cycles never reaches `dat_o`.

**Bounce during qualification**
- The counter restarts from the next clean entry into CHK.
- Qualification is never carried over from an earlier attempt.

**Output activity**
- `dat_o` changes at most once per `STABLE`+1 cycles.
- Downstream edge detection therefore sees one edge per qualified transition.

## Test plan
All scenarios use `STABLE`=4 and `GLITCH_W`=3.

1. Reset with `dat_i`=1 held, then release `rstn`. Required:
   - `dat_o`, `busy` and `glitch_cnt` read 0 during reset.
   - `dat_o` rises exactly 6 edges after the first capture edge.
2. Clean level change: `dat_i` 0→1, hold 10 cycles, then 1→0. Required:
   - `busy` is high for 4 cycles on each transition.
   - `dat_o` rises at k+6 and falls at j+6.
   - `glitch_cnt` stays 0.
3. Bounce: `dat_i`=1 for 2 cycles, 0 for 1 cycle, then 1 and held. Required:
   - One abort, so `glitch_cnt`=1.
   - `dat_o` rises 6 edges after the final stable capture, not the first one.
4. Glitch saturation:
   - Apply 10 single-cycle high pulses spaced 8 cycles apart. Required: `glitch_cnt` saturates at 7 and `dat_o` stays 0 throughout.
   - Then assert `glitch_clr` in the same cycle as an abort. Required: `glitch_cnt`=0.
5. Reset during qualification: drop `rstn` while in CHK_H with cnt=2. Required:
   - Everything is cleared and `glitch_cnt` is unchanged from 0.
   - After release with `dat_i` still 1, full 6-edge latency.
6. Minimum `STABLE`=1 (separate instance): `dat_i` 0→1. Required:
   - `dat_o` rises at edge k+3.
   - A 1-cycle low pulse while HIGH enters CHK_L and is aborted, so `glitch_cnt`=1 and `dat_o` stays 1.
